// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: machine words, instruction words, the IF/ID
// pipeline register layout and the fetch FSM state encoding.
package fetch_pkg;

    typedef logic [63:0] word_t;
    typedef logic [31:0] inst_t;

    localparam word_t DEFAULT_RESET_PC = 64'h8000_0000;

    // Register handed to decode; inst_counter is the sequence number of the
    // word among all delivered words (always zero when counting is disabled).
    typedef struct packed {
        inst_t inst;
        word_t inst_pc;
        logic  valid;
        word_t inst_counter;
    } if_id;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        FLUSH
    } fetch_state_t;

    // Sequential fetch step; 64-bit wrap is intentional.
    function automatic word_t next_pc(input word_t pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/fetch_holdbuf.sv
// Single-entry {inst, pc} buffer that parks a returned word while decode is
// stalled, so the bus transaction can complete without being reissued.
module fetch_holdbuf
    import fetch_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  logic  clear,
    input  inst_t inst_in,
    input  word_t pc_in,
    output logic  valid,
    output inst_t inst,
    output word_t pc
);

    // Load has priority: a word cannot arrive and be consumed in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            inst  <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= inst_in;
            pc    <= pc_in;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding bus request, registered IF/ID
// output with stall hold and redirect flush.
// Optional feature: define FETCH_INST_COUNTER_EN to number delivered words
// in if_id_state.inst_counter; otherwise the field is tied to zero.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output if_id        if_id_state,
    output logic        busy
);

    fetch_state_t state;
    word_t        pc;        // next fetch target on the current path
    word_t        req_addr;  // address of the outstanding request (old path while flushing)
    logic         req_vld;
    if_id         if_id_q;
    word_t        cnt_cur;

    logic  hb_load, hb_clear, hb_valid;
    inst_t hb_inst;
    word_t hb_pc;

    logic load_resp, load_held;

    // A response goes straight to decode only if nothing is blocking it;
    // a held word is released as soon as the stall drops.
    assign load_resp = (state == REQ) && iresp_data_ok && !redirect_valid && !stall;
    assign load_held = (state == HOLD) && hb_valid && !redirect_valid && !stall;
    assign hb_load   = (state == REQ) && iresp_data_ok && !redirect_valid && stall;
    assign hb_clear  = (state == HOLD) && (redirect_valid || !stall);

    fetch_holdbuf u_holdbuf (
        .clk     (clk),
        .reset   (reset),
        .load    (hb_load),
        .clear   (hb_clear),
        .inst_in (iresp_data),
        .pc_in   (pc),
        .valid   (hb_valid),
        .inst    (hb_inst),
        .pc      (hb_pc)
    );

`ifdef FETCH_INST_COUNTER_EN
    word_t inst_cnt;

    // Count only words that actually reach decode; dropped words never load.
    always_ff @(posedge clk) begin
        if (reset)
            inst_cnt <= '0;
        else if (load_resp || load_held)
            inst_cnt <= inst_cnt + 64'd1;
    end

    assign cnt_cur = inst_cnt;
`else
    assign cnt_cur = '0;
`endif

    // Fetch FSM: PC tracking, request issue and flush of stale responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            req_vld  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= REQ;
                    req_vld <= 1'b1;
                    if (redirect_valid) begin
                        pc       <= redirect_pc;
                        req_addr <= redirect_pc;
                    end else begin
                        req_addr <= pc;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        // Bus is free again if the response landed this cycle;
                        // otherwise the old request must be drained first.
                        if (iresp_data_ok)
                            req_addr <= redirect_pc;
                        else
                            state <= FLUSH;
                    end else if (iresp_data_ok) begin
                        if (stall) begin
                            state   <= HOLD;
                            req_vld <= 1'b0;
                        end else begin
                            pc       <= next_pc(pc);
                            req_addr <= next_pc(pc);
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        state    <= REQ;
                        req_vld  <= 1'b1;
                        pc       <= redirect_pc;
                        req_addr <= redirect_pc;
                    end else if (!stall) begin
                        state    <= REQ;
                        req_vld  <= 1'b1;
                        pc       <= next_pc(hb_pc);
                        req_addr <= next_pc(hb_pc);
                    end
                end
                FLUSH: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (iresp_data_ok) begin
                            state    <= REQ;
                            req_addr <= redirect_pc;
                        end
                    end else if (iresp_data_ok) begin
                        state    <= REQ;
                        req_addr <= pc;
                    end
                end
                default: begin
                    state   <= IDLE;
                    req_vld <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID register: redirect flushes, loads deliver, stall freezes, else bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_q <= '0;
        end else if (redirect_valid) begin
            if_id_q.valid <= 1'b0;
        end else if (load_resp) begin
            if_id_q <= '{inst: iresp_data, inst_pc: pc, valid: 1'b1, inst_counter: cnt_cur};
        end else if (load_held) begin
            if_id_q <= '{inst: hb_inst, inst_pc: hb_pc, valid: 1'b1, inst_counter: cnt_cur};
        end else if (!stall) begin
            if_id_q.valid <= 1'b0;
        end
    end

    assign ireq_valid  = req_vld;
    assign ireq_addr   = req_addr;
    // A request is outstanding exactly in REQ and FLUSH.
    assign busy        = req_vld;
    assign if_id_state = if_id_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run checked by a transaction-level model (expected fetch stream).
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
`ifdef FETCH_INST_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    if_id        if_id_state;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_state    (if_id_state),
        .busy           (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] exp_cnt(input int n);
        return CNT_EN ? 64'(n) : 64'd0;
    endfunction

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        iresp_data_ok = 1'b0; iresp_data = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h1234_5678;
        iresp_data_ok = 1'b0; iresp_data = '0;
        tick(); tick();
        vectors++; if (ireq_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ireq_valid: got %b want 0", ireq_valid); end
        vectors++; if (if_id_state !== '0) begin miscompares++; $display("FAIL reset_if_id: got %h want 0", if_id_state); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        tick();
        vectors++; if (ireq_valid !== 1'b1 || ireq_addr !== RST_PC) begin miscompares++; $display("FAIL reset_first_req: got v=%b a=%h want v=1 a=%h", ireq_valid, ireq_addr, RST_PC); end
    endtask

    task automatic test_zero_wait();
        do_reset(); tick();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (ireq_valid !== 1'b1 || ireq_addr !== RST_PC + 64'(4*i)) begin miscompares++; $display("FAIL zw_addr%0d: got v=%b a=%h want a=%h", i, ireq_valid, ireq_addr, RST_PC + 64'(4*i)); end
            iresp_data_ok = 1'b1; iresp_data = 32'h0000_0013;
            tick();
            vectors++; if (if_id_state.valid !== 1'b1 || if_id_state.inst_pc !== RST_PC + 64'(4*i) || if_id_state.inst !== 32'h13) begin miscompares++; $display("FAIL zw_deliver%0d: got v=%b pc=%h inst=%h want pc=%h", i, if_id_state.valid, if_id_state.inst_pc, if_id_state.inst, RST_PC + 64'(4*i)); end
        end
        iresp_data_ok = 1'b0;
        tick();
        vectors++; if (if_id_state.valid !== 1'b0) begin miscompares++; $display("FAIL zw_bubble: got valid %b want 0", if_id_state.valid); end
    endtask

    task automatic test_stall_hold();
        do_reset(); tick();
        iresp_data_ok = 1'b1; iresp_data = 32'h0000_000A;
        tick();
        iresp_data = 32'h0000_000B; stall = 1'b1;
        tick();
        iresp_data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (ireq_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL hold_noreq%0d: got v=%b busy=%b want 0", i, ireq_valid, busy); end
            vectors++; if (if_id_state.inst !== 32'hA || if_id_state.inst_pc !== RST_PC || if_id_state.valid !== 1'b1 || if_id_state.inst_counter !== exp_cnt(0)) begin miscompares++; $display("FAIL hold_frozen%0d: got %h", i, if_id_state); end
            if (i < 2) tick();
        end
        stall = 1'b0;
        tick();
        vectors++; if (if_id_state.inst !== 32'hB || if_id_state.inst_pc !== RST_PC + 64'd4 || if_id_state.valid !== 1'b1 || if_id_state.inst_counter !== exp_cnt(1)) begin miscompares++; $display("FAIL hold_release: got inst=%h pc=%h v=%b cnt=%0d", if_id_state.inst, if_id_state.inst_pc, if_id_state.valid, if_id_state.inst_counter); end
        vectors++; if (ireq_valid !== 1'b1 || ireq_addr !== RST_PC + 64'd8) begin miscompares++; $display("FAIL hold_next_req: got v=%b a=%h want a=%h", ireq_valid, ireq_addr, RST_PC + 64'd8); end
    endtask

    task automatic test_flush_pending();
        do_reset(); tick();
        iresp_data_ok = 1'b1; iresp_data = 32'h1;
        tick(); tick();
        iresp_data_ok = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
        tick();
        redirect_valid = 1'b0;
        vectors++; if (if_id_state.valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", if_id_state.valid); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (ireq_valid !== 1'b1 || ireq_addr !== RST_PC + 64'd8 || busy !== 1'b1) begin miscompares++; $display("FAIL flush_old_addr%0d: got v=%b a=%h want a=%h", i, ireq_valid, ireq_addr, RST_PC + 64'd8); end
            if (i < 3) tick();
        end
        iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_BEEF;
        tick();
        vectors++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_1000 || if_id_state.valid !== 1'b0) begin miscompares++; $display("FAIL flush_drop: got v=%b a=%h ifv=%b want a=80001000 ifv=0", ireq_valid, ireq_addr, if_id_state.valid); end
        iresp_data = 32'h0000_1111;
        tick();
        iresp_data_ok = 1'b0;
        vectors++; if (if_id_state.inst_pc !== 64'h8000_1000 || if_id_state.inst !== 32'h1111 || if_id_state.valid !== 1'b1 || if_id_state.inst_counter !== exp_cnt(2)) begin miscompares++; $display("FAIL flush_new_path: got pc=%h inst=%h v=%b cnt=%0d", if_id_state.inst_pc, if_id_state.inst, if_id_state.valid, if_id_state.inst_counter); end
    endtask

    task automatic test_redirect_dataok();
        do_reset(); tick();
        iresp_data_ok = 1'b1; iresp_data = 32'h0BAD_0BAD; redirect_valid = 1'b1; redirect_pc = 64'h9000_0000;
        tick();
        redirect_valid = 1'b0;
        vectors++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h9000_0000 || if_id_state.valid !== 1'b0) begin miscompares++; $display("FAIL rdok_req: got v=%b a=%h ifv=%b want a=90000000 ifv=0", ireq_valid, ireq_addr, if_id_state.valid); end
        iresp_data = 32'h0000_2222;
        tick();
        iresp_data_ok = 1'b0;
        vectors++; if (if_id_state.inst_pc !== 64'h9000_0000 || if_id_state.inst !== 32'h2222 || if_id_state.inst_counter !== exp_cnt(0)) begin miscompares++; $display("FAIL rdok_deliver: got pc=%h inst=%h cnt=%0d", if_id_state.inst_pc, if_id_state.inst, if_id_state.inst_counter); end
    endtask

    task automatic test_redirect_hold();
        do_reset(); tick();
        iresp_data_ok = 1'b1; iresp_data = 32'hA;
        tick();
        iresp_data = 32'hB; stall = 1'b1;
        tick();
        iresp_data_ok = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'hA000_0000;
        tick();
        redirect_valid = 1'b0;
        vectors++; if (if_id_state.valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 64'hA000_0000) begin miscompares++; $display("FAIL rhold_flush: got ifv=%b v=%b a=%h want ifv=0 a=a0000000", if_id_state.valid, ireq_valid, ireq_addr); end
        stall = 1'b0; iresp_data_ok = 1'b1; iresp_data = 32'hC;
        tick();
        iresp_data_ok = 1'b0;
        vectors++; if (if_id_state.inst_pc !== 64'hA000_0000 || if_id_state.inst !== 32'hC || if_id_state.inst_counter !== exp_cnt(1)) begin miscompares++; $display("FAIL rhold_after: got pc=%h inst=%h cnt=%0d", if_id_state.inst_pc, if_id_state.inst, if_id_state.inst_counter); end
    endtask

    task automatic test_counter();
        do_reset(); tick();
        iresp_data_ok = 1'b1; iresp_data = 32'h13;
        tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 64'hB000_0000;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        iresp_data_ok = 1'b0;
        vectors++; if (if_id_state.inst_pc !== 64'hB000_0004 || if_id_state.inst_counter !== exp_cnt(4)) begin miscompares++; $display("FAIL counter_last: got pc=%h cnt=%0d want pc=b0000004 cnt=%0d", if_id_state.inst_pc, if_id_state.inst_counter, exp_cnt(4)); end
    endtask

    task automatic test_wrap();
        do_reset(); tick();
        iresp_data_ok = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        iresp_data_ok = 1'b0;
        vectors++; if (if_id_state.inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC || ireq_addr !== 64'd0) begin miscompares++; $display("FAIL wrap: got pc=%h next=%h want next=0", if_id_state.inst_pc, ireq_addr); end
    endtask

    // Model: the delivered stream must be consecutive words from the most
    // recent redirect target, each carrying memory contents for its address.
    task automatic test_random();
        if_id        o_ifid;
        logic        o_req, p_ok, p_stall, p_redir;
        logic [63:0] o_addr, p_rpc, exp_pc;
        int          ndel, lat;
        do_reset();
        ndel = 0; lat = 0; exp_pc = RST_PC;
        o_ifid = if_id_state; o_req = ireq_valid; o_addr = ireq_addr;
        p_ok = 1'b0; p_stall = 1'b0; p_redir = 1'b0; p_rpc = '0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (p_redir) begin
                vectors++; if (if_id_state.valid !== 1'b0) begin miscompares++; $display("FAIL rnd_flush c%0d: valid %b want 0", c, if_id_state.valid); end
                exp_pc = p_rpc;
            end else if (p_stall) begin
                vectors++; if (if_id_state !== o_ifid) begin miscompares++; $display("FAIL rnd_hold c%0d: got %h want %h", c, if_id_state, o_ifid); end
            end else if (if_id_state.valid === 1'b1) begin
                vectors++;
                if (if_id_state.inst_pc !== exp_pc || if_id_state.inst !== mem_word(exp_pc) || if_id_state.inst_counter !== exp_cnt(ndel)) begin
                    miscompares++; $display("FAIL rnd_deliver c%0d: got pc=%h inst=%h cnt=%0d want pc=%h inst=%h cnt=%0d", c, if_id_state.inst_pc, if_id_state.inst, if_id_state.inst_counter, exp_pc, mem_word(exp_pc), exp_cnt(ndel));
                end
                exp_pc = exp_pc + 64'd4;
                ndel++;
            end
            if (o_req && !p_ok) begin
                vectors++; if (ireq_valid !== 1'b1 || ireq_addr !== o_addr) begin miscompares++; $display("FAIL rnd_req_stable c%0d: got v=%b a=%h want v=1 a=%h", c, ireq_valid, ireq_addr, o_addr); end
            end else if (ireq_valid) begin
                vectors++; if (ireq_addr !== exp_pc) begin miscompares++; $display("FAIL rnd_req_addr c%0d: got %h want %h", c, ireq_addr, exp_pc); end
            end
            vectors++; if (busy !== ireq_valid) begin miscompares++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, ireq_valid); end
            o_ifid = if_id_state; o_req = ireq_valid; o_addr = ireq_addr;
            p_stall = ($urandom_range(0, 3) == 0);
            p_redir = ($urandom_range(0, 15) == 0);
            p_rpc = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : ({$urandom, $urandom} & ~64'h3);
            p_ok = 1'b0;
            if (ireq_valid) begin
                if (lat == 0) begin p_ok = 1'b1; lat = $urandom_range(0, 3); end
                else lat--;
            end
            stall = p_stall; redirect_valid = p_redir; redirect_pc = p_rpc;
            iresp_data_ok = p_ok; iresp_data = mem_word(ireq_addr);
        end
        vectors++; if (ndel < 100) begin miscompares++; $display("FAIL rnd_progress: delivered %0d want >= 100", ndel); end
        stall = 1'b0; redirect_valid = 1'b0; iresp_data_ok = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall_hold();
        test_flush_pending();
        test_redirect_dataok();
        test_redirect_hold();
        test_counter();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
